// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake position generator.
package snake_pkg;

  localparam int unsigned SEG_W = 20;
  localparam int unsigned N_SEG = 33;
  localparam logic [SEG_W-1:0] SENTINEL = {10'h3FF, 10'h3FF};

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // LSB of segment k on the position bus; the head (k=0) occupies the top slot.
  function automatic int unsigned seg_lo(input int unsigned k);
    return (N_SEG - 1 - k) * SEG_W;
  endfunction

  function automatic dir_e dir_opposite(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/move_timer.sv
// Move-tick divider: runs only while enabled, pulses on the last count.
module move_timer #(
  parameter int unsigned TICK_DIV = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/snake_position_gen.sv
// Snake state: run/dead FSM, heading, body shift chain, growth and self-collision.
module snake_position_gen
  import snake_pkg::*;
#(
  parameter int unsigned STEP     = 10,
  parameter int unsigned H_MAX    = 640,
  parameter int unsigned V_MAX    = 480,
  parameter int unsigned TICK_DIV = 2_500_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   grow,
  output logic [N_SEG*SEG_W-1:0] position,
  output logic [5:0]             length,
  output logic                   move_tick,
  output logic                   dead
);

  localparam logic [9:0] X_LAST = 10'(H_MAX - STEP);
  localparam logic [9:0] Y_LAST = 10'(V_MAX - STEP);
  localparam logic [9:0] STEP_C = 10'(STEP);
  localparam logic [SEG_W-1:0] HEAD_RST = {10'(V_MAX / 2), 10'(H_MAX / 2)};

  state_e           state_q, state_d;
  dir_e             heading_q, heading_d, next_dir_q, next_dir_d;
  logic             grow_pend_q, grow_pend_d;
  logic [5:0]       length_q, length_d;
  logic             move_tick_q, move_tick_d;
  logic             dead_q, dead_d;
  logic [SEG_W-1:0] head_q, head_d;
  logic [SEG_W-1:0] body_q [1:N_SEG-1];
  logic [SEG_W-1:0] body_d [1:N_SEG-1];

  logic       tick_s, hit_s, move_s, any_btn_s, req_valid_s, req_ok_s;
  dir_e       req_dir_s;
  logic [9:0] x_s, y_s, step_x_s, step_y_s;

  move_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_RUN),
    .tick  (tick_s)
  );

  assign any_btn_s = btn_up | btn_down | btn_left | btn_right;
  assign move_s    = tick_s && !hit_s;
  assign x_s       = head_q[9:0];
  assign y_s       = head_q[19:10];

  // Reversal is only refused once there is a body to reverse into.
  always_comb begin
    req_valid_s = 1'b1;
    req_dir_s   = DIR_RIGHT;
    if (btn_up) begin
      req_dir_s = DIR_UP;
    end else if (btn_down) begin
      req_dir_s = DIR_DOWN;
    end else if (btn_left) begin
      req_dir_s = DIR_LEFT;
    end else if (btn_right) begin
      req_dir_s = DIR_RIGHT;
    end else begin
      req_valid_s = 1'b0;
    end
    req_ok_s = req_valid_s &&
               !((length_q > 6'd1) && (req_dir_s == dir_opposite(heading_q)));
  end

  // Only meaningful in the cycle right after a move, when head_q is the new head.
  always_comb begin
    hit_s = 1'b0;
    for (int unsigned k = 1; k < N_SEG; k++) begin
      if (move_tick_q && (6'(k) < length_q) && (body_q[k] == head_q)) begin
        hit_s = 1'b1;
      end
    end
  end

  always_comb begin
    step_x_s = x_s;
    step_y_s = y_s;
    case (next_dir_q)
      DIR_UP:    step_y_s = (y_s == 10'd0)  ? Y_LAST : y_s - STEP_C;
      DIR_DOWN:  step_y_s = (y_s == Y_LAST) ? 10'd0  : y_s + STEP_C;
      DIR_LEFT:  step_x_s = (x_s == 10'd0)  ? X_LAST : x_s - STEP_C;
      DIR_RIGHT: step_x_s = (x_s == X_LAST) ? 10'd0  : x_s + STEP_C;
      default:   step_x_s = x_s;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    heading_d   = heading_q;
    next_dir_d  = next_dir_q;
    grow_pend_d = grow_pend_q | grow;
    length_d    = length_q;
    head_d      = head_q;
    move_tick_d = move_s;
    for (int unsigned k = 1; k < N_SEG; k++) begin
      body_d[k] = body_q[k];
    end

    case (state_q)
      ST_IDLE: state_d = any_btn_s ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = hit_s ? ST_DEAD : ST_RUN;
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_DEAD) && req_ok_s) begin
      next_dir_d = req_dir_s;
    end else begin
      next_dir_d = next_dir_q;
    end

    // Slots at or beyond the new length are stored as sentinel so the bus needs no masking.
    if (move_s) begin
      heading_d   = next_dir_q;
      head_d      = {step_y_s, step_x_s};
      grow_pend_d = 1'b0;
      if ((grow_pend_q || grow) && (length_q < 6'(N_SEG))) begin
        length_d = length_q + 6'd1;
      end else begin
        length_d = length_q;
      end
      body_d[1] = (length_d > 6'd1) ? head_q : SENTINEL;
      for (int unsigned k = 2; k < N_SEG; k++) begin
        body_d[k] = (6'(k) < length_d) ? body_q[k-1] : SENTINEL;
      end
    end else begin
      head_d = head_q;
    end

    dead_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      heading_q   <= DIR_RIGHT;
      next_dir_q  <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
      length_q    <= 6'd1;
      move_tick_q <= 1'b0;
      dead_q      <= 1'b0;
      head_q      <= HEAD_RST;
      for (int unsigned k = 1; k < N_SEG; k++) begin
        body_q[k] <= SENTINEL;
      end
    end else begin
      state_q     <= state_d;
      heading_q   <= heading_d;
      next_dir_q  <= next_dir_d;
      grow_pend_q <= grow_pend_d;
      length_q    <= length_d;
      move_tick_q <= move_tick_d;
      dead_q      <= dead_d;
      head_q      <= head_d;
      for (int unsigned k = 1; k < N_SEG; k++) begin
        body_q[k] <= body_d[k];
      end
    end
  end

  always_comb begin
    position = {(N_SEG*SEG_W){1'b0}};
    position[seg_lo(0) +: SEG_W] = head_q;
    for (int unsigned k = 1; k < N_SEG; k++) begin
      position[seg_lo(k) +: SEG_W] = body_q[k];
    end
  end

  assign length    = length_q;
  assign move_tick = move_tick_q;
  assign dead      = dead_q;

endmodule
